// File: rtl/level_sequencer.sv
// Per-frame game-level controller: owns level, lives and cumulative score, and
// sequences the collision block through intro, play, pause and miss phases.
module level_sequencer #(
    parameter int NUM_LEVELS   = 4,
    parameter int LIVES_INIT   = 3,
    parameter int SCORE_TARGET = 5,
    parameter int INTRO_FRAMES = 120,
    parameter int MISS_FRAMES  = 60
) (
    input  logic       frame_clk,
    input  logic       level_rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [7:0] score,
    input  logic       miss,
    output logic [7:0] lvl_num,
    output logic [2:0] lives,
    output logic [9:0] total_score,
    output logic       coll_rst,
    output logic       coll_hold,
    output logic [2:0] state,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INTRO     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        MISS_WAIT = 3'd4,
        GAME_OVER = 3'd5,
        WIN       = 3'd6
    } state_t;

    localparam logic [8:0] INTRO_LOAD = 9'(INTRO_FRAMES - 1);
    localparam logic [8:0] MISS_LOAD  = 9'(MISS_FRAMES - 1);
    localparam logic [7:0] LAST_LVL   = 8'(NUM_LEVELS);
    localparam logic [7:0] TARGET     = 8'(SCORE_TARGET);
    localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);

    state_t     st, st_nxt;
    logic [8:0] timer, timer_nxt;
    logic [7:0] lvl_nxt;
    logic [2:0] lives_nxt;
    logic [9:0] total_nxt;
    logic       start_q, pause_q, miss_q;
    logic [7:0] score_q;
    logic       start_rise, pause_rise, miss_rise;

    assign start_rise = start_btn & ~start_q;
    assign pause_rise = pause_btn & ~pause_q;
    assign miss_rise  = miss & ~miss_q;
    assign state      = st;

    always_comb begin
        st_nxt    = st;
        timer_nxt = timer;
        lvl_nxt   = lvl_num;
        lives_nxt = lives;
        total_nxt = total_score;

        // Score credit is independent of the transition taken this frame.
        if (st == PLAY && score == score_q + 8'd1 && total_score != 10'd1023)
            total_nxt = total_score + 10'd1;

        case (st)
            IDLE: begin
                if (start_rise) begin
                    st_nxt    = INTRO;
                    lvl_nxt   = 8'd1;
                    lives_nxt = LIVES_RST;
                    total_nxt = '0;
                    timer_nxt = INTRO_LOAD;
                end
            end
            INTRO: begin
                if (timer == '0) st_nxt = PLAY;
                else             timer_nxt = timer - 9'd1;
            end
            PLAY: begin
                if (miss_rise) begin
                    if (lives != '0) lives_nxt = lives - 3'd1;
                    if (lives <= 3'd1) begin
                        st_nxt = GAME_OVER;
                    end else begin
                        st_nxt    = MISS_WAIT;
                        timer_nxt = MISS_LOAD;
                    end
                end else if (score >= TARGET) begin
                    if (lvl_num >= LAST_LVL) begin
                        st_nxt = WIN;
                    end else begin
                        st_nxt    = INTRO;
                        lvl_nxt   = lvl_num + 8'd1;
                        timer_nxt = INTRO_LOAD;
                    end
                end else if (pause_rise) begin
                    st_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_rise) st_nxt = PLAY;
            end
            MISS_WAIT: begin
                if (timer == '0) begin
                    st_nxt    = INTRO;
                    timer_nxt = INTRO_LOAD;
                end else begin
                    timer_nxt = timer - 9'd1;
                end
            end
            GAME_OVER, WIN: begin
                if (start_rise) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Edge registers reset high so inputs held through reset do not fire.
    always_ff @(posedge frame_clk or posedge level_rst) begin
        if (level_rst) begin
            st          <= IDLE;
            timer       <= '0;
            lvl_num     <= 8'd1;
            lives       <= LIVES_RST;
            total_score <= '0;
            coll_rst    <= 1'b0;
            coll_hold   <= 1'b1;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
            miss_q      <= 1'b1;
            score_q     <= '0;
        end else begin
            st          <= st_nxt;
            timer       <= timer_nxt;
            lvl_num     <= lvl_nxt;
            lives       <= lives_nxt;
            total_score <= total_nxt;
            coll_rst    <= (st_nxt == INTRO) && (st != INTRO);
            coll_hold   <= (st_nxt != PLAY);
            game_over   <= (st_nxt == GAME_OVER);
            game_won    <= (st_nxt == WIN);
            start_q     <= start_btn;
            pause_q     <= pause_btn;
            miss_q      <= miss;
            score_q     <= score;
        end
    end

endmodule
